if_fetch_stage: RTL and testbench

Instruction-fetch stage that drives the hazard detection unit's inputs downstream: PC register, next-PC selection, a single-request instruction-memory handshake with wait states, and the IF/ID pipeline register.
- Consumes pc_write, ifid_write and ifid_flush from the hazard detection unit.
- Consumes the branch target from ID.
- Produces the IF/ID instruction whose rs/rt fields the hazard unit inspects.

---
 rtl/if_fetch_stage_pkg.sv | 13 +
 rtl/if_fetch_stage_if.sv | 26 ++
 rtl/if_fetch_stage_if_id_reg.sv | 56 +++++
 rtl/if_fetch_stage.sv | 159 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_INCR   = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the memory.
interface if_fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// Generic pipeline register for IF/ID: write enable plus synchronous flush to a NOP bubble.
import if_fetch_stage_pkg::*;

module if_id_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              flush,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [ADDR_W-1:0] pc4_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc4,
  output logic              valid
);

  logic [DATA_W-1:0] instr_d, instr_q;
  logic [ADDR_W-1:0] pc4_d, pc4_q;
  logic              valid_d, valid_q;

  // Flush wins over write so a squashed slot can never carry a live instruction.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = DATA_W'(NOP_INSTR);
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (we) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= DATA_W'(NOP_INSTR);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, next-PC select, single-outstanding imem handshake with skid buffer, IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating stall/flush counters.
import if_fetch_stage_pkg::*;

module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              ifid_write,
  input  logic              ifid_flush,
  input  logic [ADDR_W-1:0] branch_target,
  if_fetch_stage_if.master  imem,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  fetch_state_e      state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              imem_req_d, imem_req_q;
  logic [DATA_W-1:0] buf_instr_d, buf_instr_q;
  logic [ADDR_W-1:0] buf_pc4_d, buf_pc4_q;

  logic              advance;
  logic [ADDR_W-1:0] pc_plus4;
  logic              reg_we;
  logic [DATA_W-1:0] reg_instr;
  logic [ADDR_W-1:0] reg_pc4;
  logic              reg_valid;

  assign advance  = pc_write & ifid_write;
  assign pc_plus4 = pc_q + ADDR_W'(PC_INCR);

  // A response that cannot advance is parked in the skid buffer so the memory never
  // has to repeat it; a flush drops both the buffer and any same-cycle response.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    reg_we      = 1'b0;
    reg_instr   = DATA_W'(NOP_INSTR);
    reg_pc4     = '0;
    reg_valid   = 1'b0;
    if (ifid_flush) begin
      pc_d        = branch_target;
      buf_instr_d = DATA_W'(NOP_INSTR);
      buf_pc4_d   = '0;
      state_d     = FETCH;
    end else begin
      unique case (state_q)
        BOOT: state_d = FETCH;
        FETCH: begin
          if (imem.imem_ready) begin
            if (advance) begin
              reg_we    = 1'b1;
              reg_instr = imem.imem_rdata;
              reg_pc4   = pc_plus4;
              reg_valid = 1'b1;
              pc_d      = pc_plus4;
            end else begin
              buf_instr_d = imem.imem_rdata;
              buf_pc4_d   = pc_plus4;
              state_d     = HOLD;
            end
          end else if (ifid_write) begin
            reg_we = 1'b1;
          end
        end
        HOLD: begin
          if (advance) begin
            reg_we    = 1'b1;
            reg_instr = buf_instr_q;
            reg_pc4   = buf_pc4_q;
            reg_valid = 1'b1;
            pc_d      = pc_plus4;
            state_d   = FETCH;
          end
        end
        default: state_d = BOOT;
      endcase
    end
    imem_req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      buf_instr_q <= DATA_W'(NOP_INSTR);
      buf_pc4_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (reg_we),
    .flush    (ifid_flush),
    .instr_in (reg_instr),
    .pc4_in   (reg_pc4),
    .valid_in (reg_valid),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4),
    .valid    (ifid_valid)
  );

  assign pc             = pc_q;
  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!advance && !ifid_flush && state_q != BOOT && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (ifid_flush && flush_cnt_q != 32'hFFFF_FFFF)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage with hand-written reset corner cases.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int pass_count  = 0;
  int check_count = 0;

  if_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem_bus ();

  if_fetch_stage #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic        iw;
    logic        fl;
    logic [31:0] bt;
    logic        rdy;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        chk_pc4;
    logic        e_valid;
    logic        e_req;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pw, logic iw, logic fl, logic [31:0] bt, logic rdy,
                              logic [31:0] rdata, logic [31:0] e_pc, logic [31:0] e_instr,
                              logic [31:0] e_pc4, logic chk_pc4, logic e_valid, logic e_req);
    vec_t v;
    v.pw = pw; v.iw = iw; v.fl = fl; v.bt = bt; v.rdy = rdy; v.rdata = rdata;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.chk_pc4 = chk_pc4;
    v.e_valid = e_valid; v.e_req = e_req;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic pw, input logic iw, input logic fl, input logic [31:0] bt,
                               input logic rdy, input logic [31:0] rdata);
    pc_write            = pw;
    ifid_write          = iw;
    ifid_flush          = fl;
    branch_target       = bt;
    imem_bus.imem_ready = rdy;
    imem_bus.imem_rdata = rdata;
  endtask

  task automatic checkAll(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                          input logic [31:0] e_pc4, input logic chk_pc4, input logic e_valid,
                          input logic e_req);
    checkOutput({tag, " pc"}, pc, e_pc);
    checkOutput({tag, " imem_addr"}, imem_bus.imem_addr, e_pc);
    checkOutput({tag, " ifid_instr"}, ifid_instr, e_instr);
    if (chk_pc4) checkOutput({tag, " ifid_pc4"}, ifid_pc4, e_pc4);
    checkOutput({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
    checkOutput({tag, " imem_req"}, {31'd0, imem_bus.imem_req}, {31'd0, e_req});
  endtask

  initial begin
    // Fetch stream, stall, wait states, flushes (incl. while in HOLD), PC wrap.
    vecs.push_back(mk(1,1,0,32'h0,1,32'h8C010004, 32'h04,32'h8C010004,32'h04,1,1,1));
    vecs.push_back(mk(1,1,0,32'h0,1,32'h00221820, 32'h08,32'h00221820,32'h08,1,1,1));
    vecs.push_back(mk(0,0,0,32'h0,1,32'hAC030008, 32'h08,32'h00221820,32'h08,1,1,0));
    vecs.push_back(mk(1,1,0,32'h0,0,32'h0,        32'h0C,32'hAC030008,32'h0C,1,1,1));
    vecs.push_back(mk(1,1,0,32'h0,1,32'h10000003, 32'h10,32'h10000003,32'h10,1,1,1));
    vecs.push_back(mk(1,1,0,32'h0,0,32'h0,        32'h10,32'h0,32'h0,0,0,1));
    vecs.push_back(mk(1,1,0,32'h0,0,32'h0,        32'h10,32'h0,32'h0,0,0,1));
    vecs.push_back(mk(1,1,0,32'h0,0,32'h0,        32'h10,32'h0,32'h0,0,0,1));
    vecs.push_back(mk(1,1,0,32'h0,1,32'h8C050010, 32'h14,32'h8C050010,32'h14,1,1,1));
    vecs.push_back(mk(1,0,1,32'h40,1,32'hDEAD0005,32'h40,32'h0,32'h0,1,0,1));
    vecs.push_back(mk(1,1,0,32'h0,1,32'h24060040, 32'h44,32'h24060040,32'h44,1,1,1));
    vecs.push_back(mk(0,0,0,32'h0,1,32'hBAD00007, 32'h44,32'h24060040,32'h44,1,1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0,        32'h44,32'h24060040,32'h44,1,1,0));
    vecs.push_back(mk(1,0,1,32'h80,0,32'h0,       32'h80,32'h0,32'h0,1,0,1));
    vecs.push_back(mk(1,1,0,32'h0,1,32'h24070080, 32'h84,32'h24070080,32'h84,1,1,1));
    vecs.push_back(mk(1,0,0,32'h0,0,32'h0,        32'h84,32'h24070080,32'h84,1,1,1));
    vecs.push_back(mk(1,0,0,32'h0,1,32'h00E83020, 32'h84,32'h24070080,32'h84,1,1,0));
    vecs.push_back(mk(1,1,0,32'h0,0,32'h0,        32'h88,32'h00E83020,32'h88,1,1,1));
    vecs.push_back(mk(1,0,1,32'hFFFF_FFFC,0,32'h0,32'hFFFF_FFFC,32'h0,32'h0,1,0,1));
    vecs.push_back(mk(1,1,0,32'h0,1,32'h3C0A0000, 32'h00,32'h3C0A0000,32'h00,1,1,1));
    vecs.push_back(mk(1,1,0,32'h0,1,32'h214A0004, 32'h04,32'h214A0004,32'h04,1,1,1));
    vecs.push_back(mk(0,0,0,32'h0,1,32'hCAFE000C, 32'h04,32'h214A0004,32'h04,1,1,0));

    rst_n = 1'b0;
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0);
    #2;
    checkAll("reset", 32'h0, 32'h0, 32'h0, 1, 0, 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("boot imem_req", {31'd0, imem_bus.imem_req}, 32'd0);
    @(posedge clk); #1;
    checkAll("after_boot", 32'h0, 32'h0, 32'h0, 1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].bt, vecs[i].rdy, vecs[i].rdata);
      @(posedge clk); #1;
      checkAll($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
               vecs[i].chk_pc4, vecs[i].e_valid, vecs[i].e_req);
    end

    // Asynchronous reset while parked in HOLD at pc=4 with a buffered word.
    #3;
    applyStimulus(1, 1, 0, 32'h0, 1, 32'h8C0D0000);
    rst_n = 1'b0;
    #1;
    checkAll("async_rst", 32'h0, 32'h0, 32'h0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reboot imem_req", {31'd0, imem_bus.imem_req}, 32'd0);
    @(posedge clk); #1;
    checkAll("reboot_fetch", 32'h0, 32'h0, 32'h0, 1, 0, 1);
    @(posedge clk); #1;
    checkAll("reboot_first", 32'h4, 32'h8C0D0000, 32'h4, 1, 1, 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
